data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//  Word-organised data RAM that consumes the ALU result as a byte address (loads/stores, LW/SW/LB/LH/LBU/LHU/SB/SH).
//  Sits directly downstream of the ALU; read_data feeds the write-back mux to the register file.
//  Single-cycle core: combinational read, synchronous byte-masked write.
// PARAMETERS
//  WORDS  64  number of 32-bit words; power of two, >=4
//  AW     $clog2(WORDS)  derived word-index width (localparam, not overridable)
// PORTS
//  clk            in   1   core clock; all writes on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  address        in   32  byte address (ALU alu_result)
//  write_data     in   32  store data (rs2), right-aligned
//  write_enable   in   1   store strobe from control unit
//  funct3         in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  read_data      out  32  aligned, sign/zero-extended load result
//  misaligned     out  1   access not naturally aligned for its size
// BEHAVIOUR
//  - Reset: async assert clears every word to 32'h0; read_data then reads 0 combinationally; misaligned is comb.
//  - Index = address[AW+1:2]; higher address bits ignored (aliasing wraps modulo WORDS*4 bytes).
//  - Byte lane = address[1:0]; halfword lane = address[1].
//  - Read: combinational, zero latency, always active (independent of write_enable).
//    B: mem[idx] byte lane, sign-extend bit 7; BU: zero-extend.
//    H: halfword lane, sign-extend bit 15; HU: zero-extend. W: full word.
//    funct3 011/110/111: read_data = 32'h0.
//  - Write: at posedge clk when write_enable=1 and rst_n=1.
//    SB: only byte lane updated with write_data[7:0]; SH: halfword lane with write_data[15:0]; SW: all 4 bytes.
//    funct3 other than 000/001/010 with write_enable: no update.
//  - Read-during-write, same index: read_data shows OLD contents until the edge, new contents after.
//  - Reset mid-operation: reset wins; a write coinciding with rst_n low is discarded.
//  - misaligned = (H/HU and address[0]) | (W and address[1:0]!=0); 0 for bytes/illegal funct3.
// CONFIGURATION
//  DATA_MEMORY_MISALIGN_CHECK_EN
//   defined: misaligned stores are suppressed (memory unchanged); misaligned loads return 32'h0; misaligned driven.
//   undefined: misaligned tied 0; low address bits are forced to alignment (H ignores bit0, W ignores bits1:0);
//     access proceeds on the aligned location.
// STRUCTURE
//  - Shared package dmem_pkg: localparams F3_B/F3_H/F3_W/F3_BU/F3_HU; typedef logic [3:0] byte_en_t.
//  - Sub-module dmem_load_align: comb lane select + sign/zero extend (word, lane, funct3 -> read_data).
//  - Top: byte-enable decode, storage array with per-byte write, async-reset clear, misalign logic.
// TESTING
//  1 Reset: hold rst_n=0, release; read addr 0x00,0xFC with LW -> 0x00000000.
//  2 SW 0xDEADBEEF @0x08, then LW @0x08 -> 0xDEADBEEF; LB @0x08 -> 0xFFFFFFEF; LBU @0x0B -> 0x000000DE.
//  3 SB 0x12 @0x09 over above -> LW @0x08 = 0xDEAD12EF; SH 0x8001 @0x0A -> LW = 0x800112EF, LH @0x0A = 0xFFFF8001, LHU = 0x00008001.
//  4 Wrap (WORDS=64): SW 0x11111111 @0x100 -> LW @0x000 = 0x11111111; same-cycle read before edge shows old value.
//  5 With _EN: SW 0xAAAAAAAA @0x0E -> misaligned=1, LW @0x0C unchanged, LW @0x0E = 0; without _EN: misaligned=0, LW @0x0C = 0xAAAAAAAA.
//  6 Assert rst_n low in the same cycle as SW 0x5 @0x10 -> word stays 0x0 after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory slice.
//   F3_*          funct3 encodings for load/store size and signedness
//   byte_en_t     per-byte write strobe of one 32-bit word (bit n -> bits 8n+7:8n)
//   store_byte_en decodes a store's funct3 and byte lane into the strobe
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef logic [3:0] byte_en_t;

   // Only SB/SH/SW write. The unsigned load encodings (BU/HU) and the
   // reserved encodings produce an empty strobe, so the word is untouched.
   function automatic byte_en_t store_byte_en(input logic [2:0] f3,
                                               input logic [1:0] lane);
      byte_en_t be;
      case (f3)
         F3_B:    be = byte_en_t'(4'b0001 << lane);
         F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
         F3_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// -----------------------------------------------------------------------------
// dmem_load_align
// Combinational load formatter: picks the byte or halfword lane out of a
// stored word and sign- or zero-extends it to 32 bits.
// Ports:
//   word_i       in  32  stored word addressed by the load
//   lane_i       in   2  byte lane (bit 1 alone selects the halfword lane)
//   funct3_i     in   3  access size/sign
//   read_data_o  out 32  right-aligned, extended load result (0 for reserved funct3)
// -----------------------------------------------------------------------------
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] read_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[7:0];
      case (lane_i)
         2'd0:    byte_sel = word_i[7:0];
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         default: byte_sel = word_i[31:24];
      endcase
      half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      read_data_o = 32'h0;
      case (funct3_i)
         F3_B:    read_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   read_data_o = {24'h0, byte_sel};
         F3_H:    read_data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   read_data_o = {16'h0, half_sel};
         F3_W:    read_data_o = word_i;
         default: read_data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Word-organised data RAM addressed by the ALU result (byte address).
// Combinational read, byte-masked write on the rising clock edge, whole array
// cleared by the asynchronous active-low reset.
// Ports:
//   clk           in   1   core clock
//   rst_n         in   1   asynchronous active-low reset (clears all words)
//   address       in  32   byte address; bits above AW+1 alias
//   write_data    in  32   store data, right-aligned
//   write_enable  in   1   store strobe
//   funct3        in   3   access size/sign
//   read_data     out 32   aligned, extended load result
//   misaligned    out  1   access not naturally aligned for its size
// Build option DATA_MEMORY_MISALIGN_CHECK_EN:
//   defined   - misaligned accesses flagged; such stores dropped, loads return 0
//   undefined - misaligned tied low; low address bits forced to alignment
// -----------------------------------------------------------------------------
module data_memory
   import dmem_pkg::*;
#(
   parameter int WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic        write_enable,
   input  logic [2:0]  funct3,
   output logic [31:0] read_data,
   output logic        misaligned
);

   localparam int AW = $clog2(WORDS);

   logic [AW-1:0] idx;
   logic [1:0]    lane;
   logic          is_h;
   logic          is_w;
   logic          access_ok;
   byte_en_t      byte_en;
   logic [31:0]   wdata_lanes;
   logic [31:0]   word_rd [WORDS];
   logic [31:0]   aligned_rd;
   logic          unused_addr_hi;

   assign idx            = address[AW+1:2];
   assign unused_addr_hi = ^address[31:AW+2];
   assign is_h           = (funct3 == F3_H) || (funct3 == F3_HU);
   assign is_w           = (funct3 == F3_W);

`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
   assign lane       = address[1:0];
   assign misaligned = (is_h && address[0]) || (is_w && (address[1:0] != 2'b00));
   assign access_ok  = !misaligned;
`else
   // Drop the low bits a naturally aligned access of this size cannot have.
   assign lane       = is_w ? 2'b00 : (is_h ? {address[1], 1'b0} : address[1:0]);
   assign misaligned = 1'b0;
   assign access_ok  = 1'b1;
`endif

   assign byte_en = (write_enable && access_ok) ? store_byte_en(funct3, lane) : 4'b0000;

   // Replicate the store data across lanes so each byte strobe picks its own copy.
   always_comb begin
      wdata_lanes = write_data;
      case (funct3)
         F3_B:    wdata_lanes = {4{write_data[7:0]}};
         F3_H:    wdata_lanes = {2{write_data[15:0]}};
         default: wdata_lanes = write_data;
      endcase
   end

   // One register per word so the asynchronous clear and per-byte update
   // stay local to each word.
   for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      logic [31:0] word_q;
      logic [31:0] word_d;

      always_comb begin
         word_d = word_q;
         if (idx == AW'(gi)) begin
            for (int b = 0; b < 4; b++) begin
               if (byte_en[b]) word_d[8*b +: 8] = wdata_lanes[8*b +: 8];
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) word_q <= 32'h0;
         else        word_q <= word_d;
      end

      assign word_rd[gi] = word_q;
   end

   dmem_load_align u_load_align (
      .word_i      (word_rd[idx]),
      .lane_i      (lane),
      .funct3_i    (funct3),
      .read_data_o (aligned_rd)
   );

   assign read_data = access_ok ? aligned_rd : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;
   import dmem_pkg::*;

   localparam int WORDS  = 64;
   localparam int NBYTES = WORDS * 4;
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        write_enable;
   logic [2:0]  funct3;
   logic [31:0] read_data;
   logic        misaligned;

   int n_cmp = 0;
   int n_bad = 0;

   data_memory #(.WORDS(WORDS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .address      (address),
      .write_data   (write_data),
      .write_enable (write_enable),
      .funct3       (funct3),
      .read_data    (read_data),
      .misaligned   (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural byte-array reference ----------------
   logic [7:0] mem_m [NBYTES];

   function automatic int size_of(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a);
      int sz = size_of(f3);
      if (!CHK) return 1'b0;
      return ((sz == 2) && (a % 2 != 0)) || ((sz == 4) && (a % 4 != 0));
   endfunction

   function automatic int model_base(input logic [2:0] f3, input logic [31:0] a);
      int sz  = size_of(f3);
      int off = int'(a % NBYTES);
      if (!CHK && sz > 0) off = off - (off % sz);
      return off;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
      int sz = size_of(f3);
      int base;
      logic [31:0] v = 32'h0;
      if (sz == 0 || model_mis(f3, a)) return 32'h0;
      base = model_base(f3, a);
      for (int i = 0; i < sz; i++) v = v | (32'(mem_m[base + i]) << (8 * i));
      if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic model_store(input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd);
      int sz = size_of(f3);
      int base;
      if (!we || f3 > 3'b010 || model_mis(f3, a)) return;
      base = model_base(f3, a);
      for (int i = 0; i < sz; i++) mem_m[base + i] = wd[8*i +: 8];
   endtask

   task automatic model_clear();
      for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h", nm, act, exp);
      end
   endtask

   // Drive one access, check the pre-edge (combinational) outputs, then clock it.
   task automatic apply(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis);
      write_enable = we;
      funct3       = f3;
      address      = a;
      write_data   = wd;
      #1;
      $display("%s we=%0b f3=%03b a=%08h wd=%08h rd=%08h mis=%0b", nm, we, f3, a, wd,
               read_data, misaligned);
      check({nm, ".rd"}, read_data, exp_rd);
      check({nm, ".mis"}, 32'(misaligned), 32'(exp_mis));
      model_store(we, f3, a, wd);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        mis;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input logic mis);
      vec_t v;
      v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.rd = rd; v.mis = mis;
      tbl.push_back(v);
   endtask

   initial begin
      rst_n        = 1'b0;
      address      = 32'h0;
      write_data   = 32'h0;
      write_enable = 1'b0;
      funct3       = F3_W;
      model_clear();

      // Stores attempted while reset is held must be ignored.
      write_enable = 1'b1;
      write_data   = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #1;
      write_enable = 1'b0;
      check("in_reset.rd", read_data, 32'h0);
      rst_n = 1'b1;

      // Directed table: expected read is the pre-edge value (old contents).
      add(0, F3_W,  32'h00,  32'h0,         32'h0,         0);
      add(0, F3_W,  32'hFC,  32'h0,         32'h0,         0);
      add(1, F3_W,  32'h08,  32'hDEADBEEF,  32'h0,         0);
      add(0, F3_W,  32'h08,  32'h0,         32'hDEADBEEF,  0);
      add(0, F3_B,  32'h08,  32'h0,         32'hFFFFFFEF,  0);
      add(0, F3_BU, 32'h0B,  32'h0,         32'h000000DE,  0);
      add(1, F3_B,  32'h09,  32'h12,        32'hFFFFFFBE,  0);
      add(0, F3_W,  32'h08,  32'h0,         32'hDEAD12EF,  0);
      add(1, F3_H,  32'h0A,  32'h8001,      32'hFFFFDEAD,  0);
      add(0, F3_W,  32'h08,  32'h0,         32'h800112EF,  0);
      add(0, F3_H,  32'h0A,  32'h0,         32'hFFFF8001,  0);
      add(0, F3_HU, 32'h0A,  32'h0,         32'h00008001,  0);
      add(0, 3'b011,32'h08,  32'h0,         32'h0,         0);
      add(1, F3_BU, 32'h08,  32'hFFFFFFFF,  32'h000000EF,  0);
      add(0, F3_W,  32'h08,  32'h0,         32'h800112EF,  0);
      add(1, F3_W,  32'h100, 32'h11111111,  32'h0,         0);
      add(0, F3_W,  32'h000, 32'h0,         32'h11111111,  0);
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
      add(1, F3_W,  32'h0E,  32'hAAAAAAAA,  32'h0,         1);
      add(0, F3_W,  32'h0C,  32'h0,         32'h0,         0);
      add(0, F3_W,  32'h0E,  32'h0,         32'h0,         1);
      add(0, F3_H,  32'h09,  32'h0,         32'h0,         1);
`else
      add(1, F3_W,  32'h0E,  32'hAAAAAAAA,  32'h0,         0);
      add(0, F3_W,  32'h0C,  32'h0,         32'hAAAAAAAA,  0);
      add(0, F3_W,  32'h0E,  32'h0,         32'hAAAAAAAA,  0);
      add(0, F3_H,  32'h09,  32'h0,         32'h000012EF,  0);
`endif

      for (int i = 0; i < tbl.size(); i++) begin
         apply($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd,
               tbl[i].rd, tbl[i].mis);
      end

      // Randomised traffic against the byte-array model; addresses span
      // four aliases of the array.
      for (int i = 0; i < 400; i++) begin
         logic        we;
         logic [2:0]  f3;
         logic [31:0] a;
         logic [31:0] wd;
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = 32'($urandom_range(0, 1023));
         wd = $urandom;
         apply($sformatf("rnd%0d", i), we, f3, a, wd, model_load(f3, a), model_mis(f3, a));
      end

      // Reset asserted in the same cycle as a store: the store is lost.
      write_enable = 1'b1;
      funct3       = F3_W;
      address      = 32'h10;
      write_data   = 32'h5;
      rst_n        = 1'b0;
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      rst_n        = 1'b1;
      model_clear();
      apply("rst_wr.lw10", 0, F3_W, 32'h10, 32'h0, 32'h0, 0);
      apply("rst_wr.lw08", 0, F3_W, 32'h08, 32'h0, 32'h0, 0);
      apply("rst_wr.lw00", 0, F3_W, 32'h00, 32'h0, 32'h0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
